hand_pos_controller: RTL

HAND_POS_CONTROLLER -- requirements
Module: hand_pos_controller

---
 rtl/hand_pos_controller.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/hand_pos_controller.sv
// Multi-hand 3-axis position controller: button-driven moves on tick strobes with
// hold-to-accelerate step sizing, per-axis clamping and a derived top point per hand.
module hand_pos_controller #(
  parameter int NUM_HANDS  = 2,
  parameter int X_W        = 12,
  parameter int Y_W        = 12,
  parameter int Z_W        = 14,
  parameter int X_MAX      = 1279,
  parameter int Y_MAX      = 719,
  parameter int Z_MAX      = 8191,
  parameter int X_INIT     = 640,
  parameter int Y_INIT     = 360,
  parameter int Z_INIT     = 1000,
  parameter int STEP_INIT  = 1,
  parameter int STEP_MAX   = 8,
  parameter int HOLD_TICKS = 4,
  parameter int TOP_DY     = 64,
  localparam int SEL_W     = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     tick_in,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     left_button,
  input  logic                     right_button,
  input  logic                     up_button,
  input  logic                     down_button,
  input  logic                     fwd_button,
  input  logic                     back_button,
  output logic [NUM_HANDS*X_W-1:0] hand_x_bottom,
  output logic [NUM_HANDS*Y_W-1:0] hand_y_bottom,
  output logic [NUM_HANDS*Z_W-1:0] hand_z_bottom,
  output logic [NUM_HANDS*X_W-1:0] hand_x_top,
  output logic [NUM_HANDS*Y_W-1:0] hand_y_top,
  output logic [NUM_HANDS*Z_W-1:0] hand_z_top,
  output logic [3:0]               step_out,
  output logic                     moving_out
);

  localparam int HC_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [SEL_W:0] NH_LIM = (SEL_W+1)'(NUM_HANDS);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              step_q, step_d;
  logic [HC_W-1:0]         hold_q, hold_d;
  logic [SEL_W-1:0]        sel_q;
  logic [X_W-1:0]          x_q [NUM_HANDS];
  logic [X_W-1:0]          x_d [NUM_HANDS];
  logic [Y_W-1:0]          y_q [NUM_HANDS];
  logic [Y_W-1:0]          y_d [NUM_HANDS];
  logic [Z_W-1:0]          z_q [NUM_HANDS];
  logic [Z_W-1:0]          z_d [NUM_HANDS];

  logic                    sel_ok, sel_chg, any_move;
  logic signed [1:0]       dx, dy, dz;
  logic [3:0]              eff_step;
  logic [4:0]              step_dbl;
  logic signed [5:0]       mv_x, mv_y, mv_z;

  function automatic logic signed [1:0] axis_dir(input logic pos, input logic neg);
    if (pos && !neg) return 2'sb01;
    if (neg && !pos) return 2'sb11;
    return 2'sb00;
  endfunction

  function automatic logic signed [5:0] scale(input logic signed [1:0] d, input logic [3:0] s);
    case (d)
      2'sb01:  return $signed({2'b00, s});
      2'sb11:  return -$signed({2'b00, s});
      default: return 6'sd0;
    endcase
  endfunction

  // Saturating add with one extra signed bit so underflow shows as a negative sum.
  function automatic logic [X_W-1:0] sat_x(input logic [X_W-1:0] c, input logic signed [5:0] m);
    logic signed [X_W:0] s;
    s = $signed({1'b0, c}) + (X_W+1)'(m);
    if (s[X_W]) return '0;
    if (s > $signed((X_W+1)'(X_MAX))) return X_W'(X_MAX);
    return s[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] sat_y(input logic [Y_W-1:0] c, input logic signed [5:0] m);
    logic signed [Y_W:0] s;
    s = $signed({1'b0, c}) + (Y_W+1)'(m);
    if (s[Y_W]) return '0;
    if (s > $signed((Y_W+1)'(Y_MAX))) return Y_W'(Y_MAX);
    return s[Y_W-1:0];
  endfunction

  function automatic logic [Z_W-1:0] sat_z(input logic [Z_W-1:0] c, input logic signed [5:0] m);
    logic signed [Z_W:0] s;
    s = $signed({1'b0, c}) + (Z_W+1)'(m);
    if (s[Z_W]) return '0;
    if (s > $signed((Z_W+1)'(Z_MAX))) return Z_W'(Z_MAX);
    return s[Z_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] sat_top(input logic [Y_W-1:0] y);
    return (y >= Y_W'(TOP_DY)) ? y - Y_W'(TOP_DY) : '0;
  endfunction

  assign sel_ok   = ({1'b0, sel_in} < NH_LIM);
  assign sel_chg  = (sel_in != sel_q);
  assign dx       = axis_dir(right_button, left_button);
  assign dy       = axis_dir(down_button, up_button);
  assign dz       = axis_dir(fwd_button, back_button);
  assign any_move = sel_ok && ((dx != 2'sb00) || (dy != 2'sb00) || (dz != 2'sb00));
  // A hand switch restarts acceleration, including a move made on the switch cycle itself.
  assign eff_step = sel_chg ? 4'(STEP_INIT) : step_q;
  assign mv_x     = scale(dx, eff_step);
  assign mv_y     = scale(dy, eff_step);
  assign mv_z     = scale(dz, eff_step);
  assign step_dbl = {step_q, 1'b0};

  always_comb begin
    for (int i = 0; i < NUM_HANDS; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      z_d[i] = z_q[i];
    end
    if (tick_in && any_move) begin
      for (int i = 0; i < NUM_HANDS; i++) begin
        if (SEL_W'(i) == sel_in) begin
          x_d[i] = sat_x(x_q[i], mv_x);
          y_d[i] = sat_y(y_q[i], mv_y);
          z_d[i] = sat_z(z_q[i], mv_z);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    hold_d  = hold_q;
    if (sel_chg || (tick_in && !any_move)) begin
      state_d = IDLE;
      step_d  = 4'(STEP_INIT);
      hold_d  = '0;
    end else if (tick_in) begin
      if (hold_q == HC_W'(HOLD_TICKS - 1)) begin
        step_d  = (step_dbl > 5'(STEP_MAX)) ? 4'(STEP_MAX) : step_dbl[3:0];
        hold_d  = '0;
        state_d = FAST;
      end else begin
        hold_d  = hold_q + HC_W'(1);
        state_d = (state_q == IDLE) ? SLOW : state_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      step_q  <= 4'(STEP_INIT);
      hold_q  <= '0;
      sel_q   <= sel_in;
      for (int i = 0; i < NUM_HANDS; i++) begin
        x_q[i] <= X_W'(X_INIT);
        y_q[i] <= Y_W'(Y_INIT);
        z_q[i] <= Z_W'(Z_INIT);
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      sel_q   <= sel_in;
      for (int i = 0; i < NUM_HANDS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
        z_q[i] <= z_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_HANDS; g++) begin : g_out
    assign hand_x_bottom[g*X_W +: X_W] = x_q[g];
    assign hand_y_bottom[g*Y_W +: Y_W] = y_q[g];
    assign hand_z_bottom[g*Z_W +: Z_W] = z_q[g];
    assign hand_x_top[g*X_W +: X_W]    = x_q[g];
    assign hand_y_top[g*Y_W +: Y_W]    = sat_top(y_q[g]);
    assign hand_z_top[g*Z_W +: Z_W]    = z_q[g];
  end

  assign step_out   = step_q;
  assign moving_out = (state_q != IDLE);

endmodule
